segre_dcache_miss_ctrl: RTL and testbench

Data-cache miss controller sitting directly downstream of the dcache tag array. It consumes the tag array's miss indication, fetches the missing line from memory over a request/grant/response handshake, and then drives the fill strobe, fill index and line data that update the tag and data arrays. It holds the core (stall) from the miss cycle until the fill has been written. It handles one outstanding miss at a time.

---
 rtl/segre_dcache_miss_ctrl.sv | 171 +++++++++++++++++
 tb/tb_segre_dcache_miss_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_dcache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// segre_pkg / segre_dcache_miss_ctrl
//
// Data-cache miss controller. Takes the tag array's miss indication, fetches
// the missing line from memory (request/grant, then rvalid with line data)
// and drives a one-cycle fill of the tag and data arrays. One outstanding
// miss at a time; the core is stalled from the miss cycle until the fill.
//
// Optional feature macro: SEGRE_DCACHE_MISS_TIMEOUT_EN
//   When defined, a WAIT that lasts TIMEOUT_CYCLES cycles without rvalid
//   re-issues the request for the same line and pulses timeout_o.
//   When undefined, WAIT waits indefinitely and timeout_o is tied low.
//
// Ports:
//   clk_i, rsn_i        clock, synchronous active-low reset
//   miss_i, addr_i      miss and address of the current access
//   mem_req_o/addr_o    line-read request (held until mem_gnt_i)
//   mem_gnt_i           memory accepts the request
//   mem_rvalid_i/rdata_i line data return
//   fill_o              one-cycle write strobe to tag/data arrays
//   fill_index_o/addr_o/data_o  fill payload, held between fills
//   stall_o             core stall
//   timeout_o           one-cycle pulse on a request retry
// ---------------------------------------------------------------------------

package segre_pkg;
  localparam int WORD_SIZE         = 32;
  localparam int DCACHE_INDEX_SIZE = 4;
endpackage

module segre_dcache_miss_ctrl
  import segre_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int BYTES_PER_LANE = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         miss_i,
  input  logic [WORD_SIZE-1:0]         addr_i,
  output logic                         mem_req_o,
  output logic [WORD_SIZE-1:0]         mem_addr_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [8*BYTES_PER_LANE-1:0]  mem_rdata_i,
  output logic                         fill_o,
  output logic [DCACHE_INDEX_SIZE-1:0] fill_index_o,
  output logic [WORD_SIZE-1:0]         fill_addr_o,
  output logic [8*BYTES_PER_LANE-1:0]  fill_data_o,
  output logic                         stall_o,
  output logic                         timeout_o
);

  localparam int LANE_SIZE       = 8*BYTES_PER_LANE;
  localparam int ADDR_BYTE_SIZE  = $clog2(BYTES_PER_LANE);
  localparam int ADDR_INDEX_SIZE = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FILL = 2'd3
  } state_t;

  state_t                         r_state;
  logic [WORD_SIZE-1:0]           r_addr;       // captured line address
  logic [ADDR_INDEX_SIZE-1:0]     r_index;      // captured line index
  logic                           r_req;
  logic                           r_fill;
  logic [WORD_SIZE-1:0]           r_fill_addr;
  logic [DCACHE_INDEX_SIZE-1:0]   r_fill_index;
  logic [LANE_SIZE-1:0]           r_fill_data;  // line buffer
  logic                           r_timeout;

  // Byte-offset bits of the access address never matter: the line is fetched whole.
  logic w_unused_addr;
  assign w_unused_addr = ^addr_i[ADDR_BYTE_SIZE-1:0];

`ifdef SEGRE_DCACHE_MISS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);
  logic [CNT_W-1:0] r_cnt;
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      // Abandons any outstanding request; a late rvalid lands in IDLE and is dropped.
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_index      <= '0;
      r_req        <= 1'b0;
      r_fill       <= 1'b0;
      r_fill_addr  <= '0;
      r_fill_index <= '0;
      r_fill_data  <= '0;
      r_timeout    <= 1'b0;
`ifdef SEGRE_DCACHE_MISS_TIMEOUT_EN
      r_cnt        <= '0;
`endif
    end else begin
      r_fill    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (miss_i) begin
            r_addr  <= {addr_i[WORD_SIZE-1:ADDR_BYTE_SIZE], {ADDR_BYTE_SIZE{1'b0}}};
            r_index <= addr_i[ADDR_INDEX_SIZE+ADDR_BYTE_SIZE-1:ADDR_BYTE_SIZE];
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          // rvalid in the grant cycle is deliberately not looked at here.
          if (mem_gnt_i) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT;
`ifdef SEGRE_DCACHE_MISS_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            // rvalid takes priority over a coincident timeout.
            r_fill_data  <= mem_rdata_i;
            r_fill_addr  <= r_addr;
            r_fill_index <= DCACHE_INDEX_SIZE'(r_index);
            r_fill       <= 1'b1;
            r_state      <= S_FILL;
          end
`ifdef SEGRE_DCACHE_MISS_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES-1)) begin
            // This is the TIMEOUT_CYCLES-th empty WAIT cycle: re-issue.
            r_cnt     <= '0;
            r_req     <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= S_REQ;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        S_FILL: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_req_o    = r_req;
  assign mem_addr_o   = r_addr;
  assign fill_o       = r_fill;
  assign fill_addr_o  = r_fill_addr;
  assign fill_index_o = r_fill_index;
  assign fill_data_o  = r_fill_data;
`ifdef SEGRE_DCACHE_MISS_TIMEOUT_EN
  assign timeout_o    = r_timeout;
`else
  assign timeout_o    = 1'b0;
  logic w_unused_timeout;
  assign w_unused_timeout = r_timeout;
`endif

  // The IDLE term is combinational so the miss cycle itself is stalled;
  // masked during reset so the stall reads low while reset is applied in IDLE.
  assign stall_o = (r_state != S_IDLE) | (miss_i & rsn_i);

endmodule

// File: tb/tb_segre_dcache_miss_ctrl.sv
module tb_segre_dcache_miss_ctrl;
  import segre_pkg::*;

  localparam int NL = 4;
  localparam int BPL = 16;
  localparam int TO = 4;
  localparam int LS = 8*BPL;

  logic clk_i = 1'b0;
  logic rsn_i, miss_i, mem_gnt_i, mem_rvalid_i;
  logic [WORD_SIZE-1:0] addr_i, mem_addr_o, fill_addr_o;
  logic [LS-1:0] mem_rdata_i, fill_data_o;
  logic mem_req_o, fill_o, stall_o, timeout_o;
  logic [DCACHE_INDEX_SIZE-1:0] fill_index_o;

  int tests = 0;
  int fails = 0;

  segre_dcache_miss_ctrl #(.NUM_LANES(NL), .BYTES_PER_LANE(BPL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .miss_i(miss_i), .addr_i(addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .fill_o(fill_o), .fill_index_o(fill_index_o), .fill_addr_o(fill_addr_o),
    .fill_data_o(fill_data_o), .stall_o(stall_o), .timeout_o(timeout_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [LS-1:0] act, input logic [LS-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic m, input logic [31:0] a,
                     input logic g, input logic v, input logic [LS-1:0] d);
    rsn_i = r; miss_i = m; addr_i = a; mem_gnt_i = g; mem_rvalid_i = v; mem_rdata_i = d;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic nxt();
    @(posedge clk_i); #1;
  endtask

  function automatic logic [LS-1:0] rep(input logic [7:0] b);
    return {BPL{b}};
  endfunction

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic r, m; logic [31:0] a; logic g, v; logic [LS-1:0] d;
    logic e_req; logic [31:0] e_maddr; logic e_fill; logic [3:0] e_idx;
    logic [31:0] e_faddr; logic [LS-1:0] e_fdata; logic e_stall;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic m, input logic [31:0] a, input logic g,
                     input logic v, input logic [LS-1:0] d, input logic er, input logic [31:0] ema,
                     input logic ef, input logic [3:0] ei, input logic [31:0] efa,
                     input logic [LS-1:0] efd, input logic es);
    vec_t t;
    t.r = r; t.m = m; t.a = a; t.g = g; t.v = v; t.d = d;
    t.e_req = er; t.e_maddr = ema; t.e_fill = ef; t.e_idx = ei;
    t.e_faddr = efa; t.e_fdata = efd; t.e_stall = es;
    vt.push_back(t);
  endtask

  // ---------------- reference model ----------------
  // Tracks the miss as a transaction: busy, request granted, fill pending.
  bit m_busy, m_gntd, m_fill, m_to;
  int m_cnt;
  logic [31:0] m_line, m_faddr;
  logic [3:0] m_idx, m_fidx;
  logic [LS-1:0] m_fdata;

  task automatic model_step();
    if (!rsn_i) begin
      m_busy = 0; m_gntd = 0; m_fill = 0; m_to = 0; m_cnt = 0;
      m_line = 0; m_faddr = 0; m_idx = 0; m_fidx = 0; m_fdata = 0;
    end else begin
      m_to = 0;
      if (!m_busy) begin
        if (miss_i) begin
          m_busy = 1; m_gntd = 0;
          m_line = (addr_i / BPL) * BPL;
          m_idx  = 4'((addr_i / BPL) % NL);
        end
      end else if (m_fill) begin
        m_busy = 0; m_fill = 0;
      end else if (!m_gntd) begin
        if (mem_gnt_i) begin m_gntd = 1; m_cnt = 0; end
      end else if (mem_rvalid_i) begin
        m_fill = 1; m_fdata = mem_rdata_i; m_faddr = m_line; m_fidx = m_idx;
      end else begin
`ifdef SEGRE_DCACHE_MISS_TIMEOUT_EN
        m_cnt++;
        if (m_cnt == TO) begin m_gntd = 0; m_to = 1; m_cnt = 0; end
`endif
      end
    end
  endtask

  task automatic model_check();
    chk("rnd_req",   LS'(mem_req_o),    LS'(m_busy && !m_gntd));
    chk("rnd_maddr", LS'(mem_addr_o),   LS'(m_line));
    chk("rnd_fill",  LS'(fill_o),       LS'(m_fill));
    chk("rnd_fidx",  LS'(fill_index_o), LS'(m_fidx));
    chk("rnd_faddr", LS'(fill_addr_o),  LS'(m_faddr));
    chk("rnd_fdata", fill_data_o,       m_fdata);
    chk("rnd_stall", LS'(stall_o),      LS'(m_busy || (miss_i && rsn_i)));
    chk("rnd_to",    LS'(timeout_o),    LS'(m_to));
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0);
    nxt(); nxt();

    // reset, minimum-penalty miss, grant+rvalid same cycle, reset during WAIT
    add(0,0,32'h0,0,0,0,            0,32'h0,   0,0,32'h0,   0,0);
    add(1,1,32'h1234,0,0,0,         0,32'h0,   0,0,32'h0,   0,1);
    add(1,0,32'h0,1,0,0,            1,32'h1230,0,0,32'h0,   0,1);
    add(1,0,32'h0,0,1,rep(8'hA5),   0,32'h1230,0,0,32'h0,   0,1);
    add(1,0,32'h0,0,0,0,            0,32'h1230,1,3,32'h1230,rep(8'hA5),1);
    add(1,0,32'h0,0,0,0,            0,32'h1230,0,3,32'h1230,rep(8'hA5),0);
    add(1,1,32'h2057,0,0,0,         0,32'h1230,0,3,32'h1230,rep(8'hA5),1);
    add(1,0,32'h0,1,1,rep(8'h11),   1,32'h2050,0,3,32'h1230,rep(8'hA5),1);
    add(1,0,32'h0,0,0,0,            0,32'h2050,0,3,32'h1230,rep(8'hA5),1);
    add(1,0,32'h0,0,1,rep(8'h22),   0,32'h2050,0,3,32'h1230,rep(8'hA5),1);
    add(1,0,32'h0,0,0,0,            0,32'h2050,1,1,32'h2050,rep(8'h22),1);
    add(1,0,32'h0,0,0,0,            0,32'h2050,0,1,32'h2050,rep(8'h22),0);
    add(1,1,32'h3000,0,0,0,         0,32'h2050,0,1,32'h2050,rep(8'h22),1);
    add(1,0,32'h0,1,0,0,            1,32'h3000,0,1,32'h2050,rep(8'h22),1);
    add(0,0,32'h0,0,0,0,            0,32'h3000,0,1,32'h2050,rep(8'h22),1);
    add(0,0,32'h0,0,0,0,            0,32'h0,   0,0,32'h0,   0,0);
    add(1,0,32'h0,0,1,rep(8'h33),   0,32'h0,   0,0,32'h0,   0,0);
    add(1,0,32'h0,0,0,0,            0,32'h0,   0,0,32'h0,   0,0);

    foreach (vt[i]) begin
      drv(vt[i].r, vt[i].m, vt[i].a, vt[i].g, vt[i].v, vt[i].d);
      smp();
      chk($sformatf("v%0d_req", i),   LS'(mem_req_o),    LS'(vt[i].e_req));
      chk($sformatf("v%0d_maddr", i), LS'(mem_addr_o),   LS'(vt[i].e_maddr));
      chk($sformatf("v%0d_fill", i),  LS'(fill_o),       LS'(vt[i].e_fill));
      chk($sformatf("v%0d_fidx", i),  LS'(fill_index_o), LS'(vt[i].e_idx));
      chk($sformatf("v%0d_faddr", i), LS'(fill_addr_o),  LS'(vt[i].e_faddr));
      chk($sformatf("v%0d_fdata", i), fill_data_o,       vt[i].e_fdata);
      chk($sformatf("v%0d_stall", i), LS'(stall_o),      LS'(vt[i].e_stall));
      chk($sformatf("v%0d_to", i),    LS'(timeout_o),    LS'(0));
      nxt();
    end

    // grant withheld 5 cycles: request stable for all 6 REQ cycles
    drv(1, 1, 32'h5678, 0, 0, 0); nxt();
    for (int c = 0; c < 6; c++) begin
      drv(1, 0, 32'hFFFF_FFFF, (c == 5), 0, 0);
      smp();
      chk("hold_req", LS'(mem_req_o), LS'(1));
      chk("hold_addr", LS'(mem_addr_o), LS'(32'h5670));
      chk("hold_nofill", LS'(fill_o), LS'(0));
      nxt();
    end
    drv(1, 0, 0, 0, 1, rep(8'h44)); nxt();
    drv(1, 0, 0, 0, 0, 0); smp();
    chk("hold_fill", LS'(fill_o), LS'(1));
    chk("hold_fidx", LS'(fill_index_o), LS'(3));
    nxt();

    // miss during WAIT ignored; held miss accepted right after FILL
    drv(1, 1, 32'h10, 0, 0, 0); nxt();
    drv(1, 0, 0, 1, 0, 0); nxt();
    drv(1, 1, 32'h40, 0, 0, 0); smp();
    chk("b2b_wait_req", LS'(mem_req_o), LS'(0));
    chk("b2b_wait_addr", LS'(mem_addr_o), LS'(32'h10));
    nxt();
    drv(1, 1, 32'h40, 0, 1, rep(8'h55)); nxt();
    smp();
    chk("b2b_fill", LS'(fill_o), LS'(1));
    chk("b2b_faddr", LS'(fill_addr_o), LS'(32'h10));
    chk("b2b_fidx", LS'(fill_index_o), LS'(1));
    chk("b2b_req_in_fill", LS'(mem_req_o), LS'(0));
    nxt();
    smp();
    chk("b2b_idle_stall", LS'(stall_o), LS'(1));
    chk("b2b_idle_req", LS'(mem_req_o), LS'(0));
    nxt();
    drv(1, 0, 0, 0, 0, 0); smp();
    chk("b2b_req2", LS'(mem_req_o), LS'(1));
    chk("b2b_addr2", LS'(mem_addr_o), LS'(32'h40));
    chk("b2b_fill_hold", LS'(fill_addr_o), LS'(32'h10));
    drv(1, 0, 0, 1, 0, 0); nxt();
    drv(1, 0, 0, 0, 1, rep(8'h66)); nxt();
    drv(1, 0, 0, 0, 0, 0); smp();
    chk("b2b_fill2", LS'(fill_o), LS'(1));
    chk("b2b_fdata2", fill_data_o, rep(8'h66));
    chk("b2b_fidx2", LS'(fill_index_o), LS'(0));
    nxt();

    // no rvalid after grant
    drv(1, 1, 32'h7788, 0, 0, 0); nxt();
    drv(1, 0, 0, 1, 0, 0); nxt();
    drv(1, 0, 0, 0, 0, 0);
`ifdef SEGRE_DCACHE_MISS_TIMEOUT_EN
    for (int c = 0; c < TO; c++) begin
      smp();
      chk("to_wait_req", LS'(mem_req_o), LS'(0));
      chk("to_wait_pulse", LS'(timeout_o), LS'(0));
      nxt();
    end
    smp();
    chk("to_pulse", LS'(timeout_o), LS'(1));
    chk("to_rereq", LS'(mem_req_o), LS'(1));
    chk("to_addr", LS'(mem_addr_o), LS'(32'h7780));
    nxt();
    smp();
    chk("to_pulse_end", LS'(timeout_o), LS'(0));
    chk("to_req_held", LS'(mem_req_o), LS'(1));
    drv(1, 0, 0, 1, 0, 0); nxt();
`else
    for (int c = 0; c < 100; c++) begin
      smp();
      chk("wait_req", LS'(mem_req_o), LS'(0));
      chk("wait_fill", LS'(fill_o), LS'(0));
      chk("wait_stall", LS'(stall_o), LS'(1));
      chk("wait_to", LS'(timeout_o), LS'(0));
      nxt();
    end
`endif
    drv(1, 0, 0, 0, 1, rep(8'h77)); nxt();
    drv(1, 0, 0, 0, 0, 0); smp();
    chk("wait_end_fill", LS'(fill_o), LS'(1));
    chk("wait_end_fdata", fill_data_o, rep(8'h77));
    nxt();

    // randomized run against the reference model
    drv(0, 0, 0, 0, 0, 0); model_step(); nxt();
    for (int c = 0; c < 600; c++) begin
      drv(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 3), $urandom(),
          ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3),
          {$urandom(), $urandom(), $urandom(), $urandom()});
      smp();
      model_check();
      model_step();
      nxt();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
